cy_skid_fifo: RTL and testbench

CY_SKID_FIFO -- requirements
Module: cy_skid_fifo

---
 rtl/cy_skid_fifo.sv | 121 ++++++++++++
 tb/tb_cy_skid_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cy_skid_fifo.sv
// cy_skid_fifo: first-word-fall-through FIFO with registered up_rdy, dn_val,
// dn_bus, occupancy and almost-full flags. Synchronous active-high reset.
module cy_skid_fifo #(
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic [DW-1:0]              up_bus,
  input  logic                       up_val,
  output logic                       up_rdy,
  output logic [DW-1:0]              dn_bus,
  output logic                       dn_val,
  input  logic                       dn_rdy,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);

  logic [DW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          dn_val_q, dn_val_d;
  logic [DW-1:0] dn_bus_q, dn_bus_d;
  logic          up_rdy_q, up_rdy_d;
  logic          af_q, af_d;

  logic push, pop;

  assign push = up_val && up_rdy_q;
  assign pop  = dn_val_q && dn_rdy;

  // Next-state for pointers, occupancy and the registered head/flag outputs.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    dn_val_d = dn_val_q;
    dn_bus_d = dn_bus_q;
    up_rdy_d = up_rdy_q;
    af_d     = af_q;

    if (i_flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      level_d  = '0;
      dn_val_d = 1'b0;
      up_rdy_d = 1'b1;
      af_d     = 1'b0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      dn_val_d = (level_d != '0);
      // When the read pointer catches the old write pointer, every stored
      // word has been consumed and the new head can only be this cycle's push.
      if (rptr_d == wptr_q) begin
        dn_bus_d = up_bus;
      end else begin
        dn_bus_d = mem_q[rptr_d[AW-1:0]];
      end
      up_rdy_d = (level_d != LVL_FULL);
      af_d     = (level_d >= LVL_AF);
    end
  end

  // Control state registers with synchronous reset taking priority.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      dn_val_q <= 1'b0;
      up_rdy_q <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      dn_val_q <= dn_val_d;
      up_rdy_q <= up_rdy_d;
      af_q     <= af_d;
    end
  end

  // Head data register; its value is meaningless while dn_val is low.
  always_ff @(posedge i_clk) begin
    dn_bus_q <= dn_bus_d;
  end

  // Storage write; contents are never cleared.
  always_ff @(posedge i_clk) begin
    if (push && !i_flush && !i_reset) begin
      mem_q[wptr_q[AW-1:0]] <= up_bus;
    end
  end

  assign up_rdy        = up_rdy_q;
  assign dn_val        = dn_val_q;
  assign dn_bus        = dn_bus_q;
  assign o_level       = level_q;
  assign o_almost_full = af_q;

endmodule

// File: tb/tb_cy_skid_fifo.sv
// Self-checking bench for cy_skid_fifo using a queue-based reference model.
module tb_cy_skid_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AFL = DEPTH - 1;

  logic          clk;
  logic          i_reset, i_flush;
  logic [DW-1:0] up_bus;
  logic          up_val, up_rdy;
  logic [DW-1:0] dn_bus;
  logic          dn_val, dn_rdy;
  logic [2:0]    o_level;
  logic          o_almost_full;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic [7:0] popped[$];
  logic       m_rdy;

  cy_skid_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush),
    .up_bus(up_bus), .up_val(up_val), .up_rdy(up_rdy),
    .dn_bus(dn_bus), .dn_val(dn_val), .dn_rdy(dn_rdy),
    .o_level(o_level), .o_almost_full(o_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the handshake rules,
  // then compare every output against the model.
  task automatic step(input logic uv, input logic [7:0] ub, input logic dr,
                      input logic fl, input logic rs);
    logic psh, pp;
    up_val = uv; up_bus = ub; dn_rdy = dr; i_flush = fl; i_reset = rs;
    psh = uv && m_rdy;
    pp  = (mq.size() > 0) && dr;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_rdy = 1'b0;
    end else if (fl) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (pp) popped.push_back(mq.pop_front());
      if (psh) mq.push_back(ub);
      m_rdy = (mq.size() < DEPTH);
    end
    #1;
    chk("level", 32'(o_level), 32'(mq.size()));
    chk("dn_val", 32'(dn_val), 32'(mq.size() > 0));
    chk("up_rdy", 32'(up_rdy), 32'(m_rdy));
    chk("afull", 32'(o_almost_full), 32'(mq.size() >= AFL));
    if (mq.size() > 0) chk("dn_bus", 32'(dn_bus), 32'(mq[0]));
  endtask

  task automatic chk_popped(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, 32'(popped.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < popped.size(); i++)
      chk(tag, 32'(popped[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int idx;
    int cyc;
    logic uv;

    m_rdy = 1'b0;
    up_val = 0; up_bus = 0; dn_rdy = 0; i_flush = 0; i_reset = 1;

    // Reset and first post-reset cycle.
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("reset_up_rdy", 32'(up_rdy), 32'd0);
    step(0, 8'h00, 0, 0, 0);
    chk("post_reset_up_rdy", 32'(up_rdy), 32'd1);

    // Streaming with dn_rdy held high.
    popped.delete();
    step(1, 8'hB3, 1, 0, 0);
    chk("stream_first_bus", 32'(dn_bus), 32'hB3);
    step(1, 8'hE3, 1, 0, 0);
    step(1, 8'hB3, 1, 0, 0);
    step(1, 8'hF9, 1, 0, 0);
    chk("stream_level", 32'(o_level), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    exp_q = '{8'hB3, 8'hE3, 8'hB3, 8'hF9};
    chk_popped("stream_order", exp_q);

    // Fill and stall, 0x05 held upstream until accepted.
    popped.delete();
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    chk("fill_afull_at3", 32'(o_almost_full), 32'd1);
    step(1, 8'h04, 0, 0, 0);
    chk("fill_full_rdy", 32'(up_rdy), 32'd0);
    chk("fill_full_level", 32'(o_level), 32'd4);
    step(1, 8'h05, 0, 0, 0);
    chk("fill_hold_level", 32'(o_level), 32'd4);
    step(1, 8'h05, 1, 0, 0);
    chk("full_pop_rdy", 32'(up_rdy), 32'd1);
    step(1, 8'h05, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_popped("fill_order", exp_q);

    // Backpressure stability.
    popped.delete();
    step(1, 8'hB1, 0, 0, 0);
    step(1, 8'hB2, 0, 0, 0);
    step(1, 8'hB3, 0, 0, 0);
    chk("bp_head", 32'(dn_bus), 32'hB1);
    step(0, 8'h00, 0, 0, 0);
    chk("bp_hold0", 32'(dn_bus), 32'hB1);
    step(0, 8'h00, 1, 0, 0);
    chk("bp_adv1", 32'(dn_bus), 32'hB2);
    step(0, 8'h00, 0, 0, 0);
    chk("bp_hold2", 32'(dn_bus), 32'hB2);
    step(0, 8'h00, 1, 0, 0);
    chk("bp_adv3", 32'(dn_bus), 32'hB3);
    step(0, 8'h00, 1, 0, 0);
    exp_q = '{8'hB1, 8'hB2, 8'hB3};
    chk_popped("bp_order", exp_q);

    // Flush with a simultaneous push.
    popped.delete();
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 0);
    step(1, 8'hA3, 0, 0, 0);
    step(1, 8'hEF, 0, 1, 0);
    chk("flush_level", 32'(o_level), 32'd0);
    chk("flush_val", 32'(dn_val), 32'd0);
    chk("flush_rdy", 32'(up_rdy), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    chk("flush_no_pops", 32'(popped.size()), 32'd0);

    // Reset mid-operation.
    popped.delete();
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 1, 0, 1);
    chk("rst_mid_rdy", 32'(up_rdy), 32'd0);
    chk("rst_mid_val", 32'(dn_val), 32'd0);
    step(1, 8'h44, 1, 0, 0);
    chk("rst_mid_rdy_back", 32'(up_rdy), 32'd1);
    chk("rst_mid_no_push", 32'(o_level), 32'd0);
    step(1, 8'h85, 0, 0, 0);
    chk("rst_first_word", 32'(dn_bus), 32'h85);
    step(0, 8'h00, 1, 0, 0);
    exp_q = '{8'h85};
    chk_popped("rst_order", exp_q);

    // Wrap-around with random valid/ready.
    popped.delete();
    void'($urandom(32'd29));
    idx = 0;
    cyc = 0;
    while (popped.size() < 20 && cyc < 600) begin
      uv = (idx < 20) && ($urandom_range(0, 3) != 0);
      if (uv && m_rdy) begin
        step(1'b1, 8'(idx), 1'($urandom_range(0, 1)), 0, 0);
        idx++;
      end else begin
        step(uv, 8'(idx), 1'($urandom_range(0, 1)), 0, 0);
      end
      cyc++;
    end
    chk("wrap_timeout", 32'(cyc < 600), 32'd1);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
    chk_popped("wrap_order", exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
